// File: rtl/avl_wb_uart_bridge.sv
// Avalon-MM slave to 8-bit Wishbone master bridge for a UART register block.
// Each access is a single Wishbone cycle with a bounded wait and a response code.
module avl_wb_uart_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic        avs_waitrequest,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic [1:0]  avs_response,
  output logic [2:0]  wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_RDV  = 2'd3;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [15:0] to_cnt;
  logic [2:0]  adr_q;
  logic [7:0]  dat_q;
  logic        we_q;
  logic [7:0]  cap_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        timeout_hit;
  logic        unused_bits;

  assign unused_bits = ^{avs_address[1:0], avs_writedata[31:8], avs_byteenable[3:1]};
  assign timeout_hit = (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      to_cnt  <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      cap_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          to_cnt <= '0;
          if (avs_write || avs_read) begin
            adr_q <= avs_address[4:2];
            dat_q <= avs_writedata[7:0];
            we_q  <= avs_write;
            // A write with lane 0 disabled carries nothing for the UART.
            state <= (avs_write && !avs_byteenable[0]) ? S_DONE : S_WB;
          end
        end
        S_WB: begin
          if (wb_ack_i) begin
            cap_q <= wb_dat_i;
            err_q <= 1'b0;
            state <= S_DONE;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        S_DONE: begin
          if (we_q) begin
            state <= S_IDLE;
          end else begin
            rdata_q <= err_q ? 32'h0 : {24'h0, cap_q};
            state   <= S_RDV;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign avs_waitrequest   = (state != S_DONE);
  assign avs_readdatavalid = (state == S_RDV);
  assign avs_response      = ((state == S_RDV) && err_q) ? 2'b10 : 2'b00;
  assign avs_readdata      = rdata_q;

  assign wb_stb_o = (state == S_WB);
  assign wb_cyc_o = (state == S_WB);
  assign wb_we_o  = (state == S_WB) && we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = 4'b0001;

endmodule

// File: tb/tb_avl_wb_uart_bridge.sv
// Bench for avl_wb_uart_bridge: directed vector table, reset sequences and
// randomized transactions against a transaction-level timing model.
module tb_avl_wb_uart_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [1:0]  avs_response;
  logic [2:0]  wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;

  avl_wb_uart_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .avs_response(avs_response),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  // ack_at: stb cycle (1-based) in which the slave acks, 0 = never.
  // exp_rdv: request-relative cycle of readdatavalid, 0 = none expected.
  typedef struct {
    logic        wr;
    logic        rd;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          ack_at;
    logic [7:0]  rdat;
    int          exp_wlow;
    int          exp_stb;
    int          exp_rdv;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    int          wlow;
    int          wlow_n;
    int          stb_n;
    int          stb_first;
    int          wb_bad;
    int          sel_bad;
    int          rdv_n;
    int          rdv_c;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          resp_bad;
  } obs_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] last_rd = 32'h0;
  vec_t        vecs [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level expectation: number of stb cycles, then fixed offsets.
  function automatic void model(inout vec_t v);
    bit skip, acked, is_rd;
    int stb;
    skip  = v.wr && !v.be[0];
    is_rd = v.rd && !v.wr;
    acked = !skip && (v.ack_at >= 1) && (v.ack_at <= TO);
    stb   = skip ? 0 : (acked ? v.ack_at : TO);
    v.exp_stb   = stb;
    v.exp_wlow  = stb + 1;
    v.exp_rdv   = is_rd ? stb + 2 : 0;
    v.exp_rdata = (is_rd && acked) ? {24'h0, v.rdat} : 32'h0;
    v.exp_resp  = (is_rd && !acked) ? 2'b10 : 2'b00;
  endfunction

  // Entered and left at 1 time unit after a rising edge; cycle 0 is the request cycle.
  task automatic run_txn(input vec_t v, input bit stray, output obs_t o);
    int stbn;
    bit drop;
    o = '{default: 0};
    o.wlow = -1;
    stbn = 0;
    drop = 0;
    avs_address = v.addr; avs_writedata = v.wdata; avs_byteenable = v.be;
    avs_write = v.wr; avs_read = v.rd;
    for (int c = 0; c < 60; c++) begin
      if (wb_stb_o) begin
        stbn++;
        wb_ack_i = (stbn == v.ack_at);
      end else begin
        wb_ack_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      wb_dat_i = wb_ack_i ? v.rdat : 8'($urandom);
      @(negedge clk);
      if (wb_stb_o) begin
        o.stb_n++;
        if (o.stb_n == 1) o.stb_first = c;
        if (wb_adr_o !== v.addr[4:2] || wb_dat_o !== v.wdata[7:0] ||
            wb_we_o !== v.wr || wb_cyc_o !== 1'b1) o.wb_bad++;
      end else if (wb_cyc_o !== 1'b0) begin
        o.wb_bad++;
      end
      if (wb_sel_o !== 4'b0001) o.sel_bad++;
      if (!avs_waitrequest) begin
        o.wlow_n++;
        if (o.wlow < 0) o.wlow = c;
        drop = 1;
      end
      if (avs_readdatavalid) begin
        o.rdv_n++;
        o.rdv_c = c;
        o.rdata = avs_readdata;
        o.resp  = avs_response;
      end else if (avs_response !== 2'b00) begin
        o.resp_bad++;
      end
      @(posedge clk); #1;
      if (drop) begin
        avs_write = 1'b0; avs_read = 1'b0; drop = 0;
      end
      if (o.wlow >= 0 && c >= o.wlow + 2) break;
    end
    avs_write = 1'b0; avs_read = 1'b0; wb_ack_i = 1'b0;
  endtask

  task automatic apply(input vec_t v, input bit stray, input string tag);
    obs_t o;
    run_txn(v, stray, o);
    chk({tag, " wait_low_cycle"}, 64'(o.wlow), 64'(v.exp_wlow));
    chk({tag, " wait_low_count"}, 64'(o.wlow_n), 64'd1);
    chk({tag, " stb_cycles"}, 64'(o.stb_n), 64'(v.exp_stb));
    if (v.exp_stb > 0) begin
      chk({tag, " stb_first"}, 64'(o.stb_first), 64'd1);
      chk({tag, " wb_signals"}, 64'(o.wb_bad), 64'd0);
    end
    chk({tag, " wb_sel"}, 64'(o.sel_bad), 64'd0);
    chk({tag, " rdv_count"}, 64'(o.rdv_n), (v.exp_rdv != 0) ? 64'd1 : 64'd0);
    if (v.exp_rdv != 0) begin
      chk({tag, " rdv_cycle"}, 64'(o.rdv_c), 64'(v.exp_rdv));
      chk({tag, " readdata"}, 64'(o.rdata), 64'(v.exp_rdata));
      chk({tag, " response"}, 64'(o.resp), 64'(v.exp_resp));
      last_rd = v.exp_rdata;
    end
    chk({tag, " resp_idle"}, 64'(o.resp_bad), 64'd0);
    chk({tag, " readdata_hold"}, 64'(avs_readdata), 64'(last_rd));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " waitrequest"}, 64'(avs_waitrequest), 64'd1);
    chk({tag, " readdatavalid"}, 64'(avs_readdatavalid), 64'd0);
    chk({tag, " readdata"}, 64'(avs_readdata), 64'd0);
    chk({tag, " response"}, 64'(avs_response), 64'd0);
    chk({tag, " stb"}, 64'(wb_stb_o), 64'd0);
    chk({tag, " cyc"}, 64'(wb_cyc_o), 64'd0);
    chk({tag, " we"}, 64'(wb_we_o), 64'd0);
    chk({tag, " adr"}, 64'(wb_adr_o), 64'd0);
    chk({tag, " dat"}, 64'(wb_dat_o), 64'd0);
    chk({tag, " sel"}, 64'(wb_sel_o), 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    //          wr    rd    addr   wdata         be    ack rdat   wlow stb rdv rdata          resp
    vecs[0] = '{1'b1, 1'b0, 5'h0C, 32'h000000A5, 4'hF, 3, 8'h00,  4, 3, 0, 32'h0,          2'b00};
    vecs[1] = '{1'b0, 1'b1, 5'h14, 32'h0,        4'hF, 1, 8'h60,  2, 1, 3, 32'h00000060,   2'b00};
    vecs[2] = '{1'b0, 1'b1, 5'h08, 32'h0,        4'hF, 0, 8'h00,  5, 4, 6, 32'h0,          2'b10};
    vecs[3] = '{1'b1, 1'b0, 5'h10, 32'h0000003C, 4'hE, 1, 8'h00,  1, 0, 0, 32'h0,          2'b00};
    vecs[4] = '{1'b0, 1'b1, 5'h1C, 32'h0,        4'hF, 4, 8'hC3,  5, 4, 6, 32'h000000C3,   2'b00};
    vecs[5] = '{1'b1, 1'b1, 5'h04, 32'hFFFFFF5A, 4'h1, 2, 8'h99,  3, 2, 0, 32'h0,          2'b00};
    vecs[6] = '{1'b0, 1'b1, 5'h00, 32'h0,        4'hF, 5, 8'h77,  5, 4, 6, 32'h0,          2'b10};

    rst_n = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = '0; wb_dat_i = '0; wb_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) apply(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Reset asserted mid-cycle while a read waits in the Wishbone phase.
    avs_address = 5'h18; avs_read = 1'b1; avs_byteenable = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst stb_before", 64'(wb_stb_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst stb", 64'(wb_stb_o), 64'd0);
    chk("midrst cyc", 64'(wb_cyc_o), 64'd0);
    chk("midrst waitrequest", 64'(avs_waitrequest), 64'd1);
    chk("midrst readdatavalid", 64'(avs_readdatavalid), 64'd0);
    avs_read = 1'b0;
    last_rd = 32'h0;
    @(posedge clk); #1;
    chk_reset_vals("midrst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    apply(vecs[1], 1'b0, "postrst");

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      v.wr     = (kind != 0);
      v.rd     = (kind != 1);
      v.addr   = 5'($urandom);
      v.wdata  = $urandom;
      v.be     = 4'($urandom);
      v.ack_at = $urandom_range(0, 6);
      v.rdat   = 8'($urandom);
      model(v);
      apply(v, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/avl_wb_uart_bridge.md
AVL_WB_UART_BRIDGE -- requirements
Module: avl_wb_uart_bridge

Interface
REQ-001 Parameters SHALL be: TIMEOUT, default 255, maximum wishbone cycles before abort (legal 1..65535).
REQ-002 Ports SHALL be, clock and reset first:
clk  in  1  single clock for all logic
rst_n  in  1  asynchronous active-low reset
avs_address  in  5  Avalon byte address; [4:2] selects UART register
avs_read  in  1  Avalon read request, held until waitrequest low
avs_write  in  1  Avalon write request, held until waitrequest low
avs_writedata  in  32  write data; only [7:0] used
avs_byteenable  in  4  byte enables; only [0] used
avs_waitrequest  out  1  high = command not yet accepted
avs_readdata  out  32  read data, valid with readdatavalid
avs_readdatavalid  out  1  one-cycle read return strobe
avs_response  out  2  2'b00 OKAY, 2'b10 SLVERR, valid with readdatavalid
wb_adr_o  out  3  wishbone register address
wb_dat_o  out  8  wishbone write data
wb_dat_i  in  8  wishbone read data
wb_we_o  out  1  wishbone write enable
wb_stb_o  out  1  wishbone strobe
wb_cyc_o  out  1  wishbone cycle
wb_sel_o  out  4  constant 4'b0001
wb_ack_i  in  1  wishbone acknowledge
REQ-003 Clock SHALL be clk; reset SHALL be rst_n, asynchronous, active-low.

Function
REQ-004 FSM states SHALL be IDLE, WB, DONE, RDV.
REQ-005 IDLE: on avs_write or avs_read high, latch avs_address[4:2], avs_writedata[7:0], direction; go to WB; avs_waitrequest stays high.
REQ-006 avs_read and avs_write both high SHALL be handled as a write; no readdatavalid generated.
REQ-007 Write with avs_byteenable[0]=0 SHALL skip WB and go directly IDLE->DONE; no wishbone cycle issued.
REQ-008 WB: wb_stb_o=wb_cyc_o=1, wb_we_o=latched direction, wb_adr_o/wb_dat_o=latched values, stable for whole state.
REQ-009 WB: wb_ack_i high SHALL capture wb_dat_i (reads), clear error flag, go to DONE; stb/cyc low from next cycle.
REQ-010 WB: timeout counter SHALL count cycles in WB; ack not seen in TIMEOUT-th cycle -> set error flag, go to DONE.
REQ-011 Ack and timeout in same cycle: ack SHALL win.
REQ-012 DONE: avs_waitrequest=0 exactly one cycle; next state RDV for reads, IDLE for writes.
REQ-013 RDV: avs_readdatavalid=1 one cycle; avs_readdata={24'h0,captured byte} (32'h0 on error); avs_response=2'b10 on error, else 2'b00; next IDLE.
REQ-014 Latency: request seen in IDLE at cycle 0; stb high from cycle 1; ack sampled at cycle n -> waitrequest low at n+1, readdatavalid at n+2.
REQ-015 avs_waitrequest SHALL be high in IDLE, WB, RDV.
REQ-016 wb_ack_i outside WB SHALL be ignored.
REQ-017 Timeout counter SHALL clear on WB entry; SHALL not wrap.
REQ-018 avs_readdatavalid and avs_response SHALL be 0 outside RDV; avs_readdata holds last value.

Reset
REQ-019 rst_n low SHALL force IDLE immediately, mid-transaction included, abandoning any wishbone cycle without a response.
REQ-020 Reset values SHALL be: avs_waitrequest=1, avs_readdatavalid=0, avs_readdata=0, avs_response=0, wb_stb_o=0, wb_cyc_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0; wb_sel_o=4'b0001 always.

Verification
REQ-021 Write addr 5'h0C, data 32'h000000A5, be 4'hF, ack 2 cycles after stb -> wb_adr_o=3, wb_dat_o=8'hA5, wb_we_o=1; waitrequest low one cycle after ack; no readdatavalid.
REQ-022 Read addr 5'h14, slave returns 8'h60 with ack on first stb cycle -> waitrequest low cycle 2, readdatavalid cycle 3, readdata=32'h00000060, response=2'b00.
REQ-023 Read, no ack, TIMEOUT=4 -> stb high exactly 4 cycles, then readdata=32'h0, response=2'b10.
REQ-024 Write with be 4'hE -> no stb/cyc ever, waitrequest low cycle 1.
REQ-025 rst_n low in WB -> stb/cyc/waitrequest at reset values same cycle; next read after release completes normally.
REQ-026 Ack and timeout coincident (TIMEOUT=3, ack in 3rd cycle) -> response=2'b00, data captured.
